// File: rtl/rx_framer_pkg.sv
// Shared types for the receive nibble framer:
// FSM states, end-of-frame status codes, preamble/SFD nibbles.
package rx_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA_LO,
    DATA_HI,
    DROP,
    RELOCK
  } state_e;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_RXER  = 3'd1;
  localparam logic [2:0] ERR_ODD   = 3'd2;
  localparam logic [2:0] ERR_LONG  = 3'd3;
  localparam logic [2:0] ERR_RUNT  = 3'd4;
  localparam logic [2:0] ERR_PHASE = 3'd5;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_nibble_framer_if.sv
// Nibble-in / byte-out bundle between the resync
// path and the receive framer.
interface rx_nibble_framer_if;
  logic       in_en;
  logic [4:0] in_d;
  logic       in_ph_err;
  logic       relock;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic [2:0] out_err;
  logic       busy;

  modport master (
    output in_en, in_d, in_ph_err,
    input  relock, out_valid, out_data,
    input  out_sof, out_eof, out_err, busy
  );

  modport slave (
    input  in_en, in_d, in_ph_err,
    output relock, out_valid, out_data,
    output out_sof, out_eof, out_err, busy
  );
endinterface

// File: rtl/rx_nibble_packer.sv
// Low-nibble latch, output byte register, sof flag
// and saturating 11-bit frame byte counter.
module rx_nibble_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        ld_lo,
  input  logic        emit,
  input  logic [3:0]  nib,
  output logic [7:0]  data,
  output logic        valid,
  output logic        sof,
  output logic [10:0] byte_cnt
);
  logic [3:0]  lo_q, lo_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic [10:0] cnt_q, cnt_d;

  always_comb begin
    lo_d    = lo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    cnt_d   = cnt_q;
    if (clr) cnt_d = '0;
    if (ld_lo) lo_d = nib;
    if (emit) begin
      data_d  = {nib, lo_q};
      valid_d = 1'b1;
      sof_d   = (cnt_q == '0);
      if (cnt_q != '1) cnt_d = cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lo_q    <= lo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign sof      = sof_q;
  assign byte_cnt = cnt_q;
endmodule

// File: rtl/rx_nibble_framer.sv
// Receive frame sequencer: preamble hunt, byte packing, eof status, relock.
// FRAMER_STATS_EN adds saturating ok/err/relock counters.
module rx_nibble_framer
  import rx_framer_pkg::*;
#(
  parameter int MAX_LEN    = 1518,
  parameter int MIN_LEN    = 64,
  parameter int PRE_MIN    = 6,
  parameter int RELOCK_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  rx_nibble_framer_if.slave io
`ifdef FRAMER_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err,
  output logic [15:0] stat_relock
`endif
);
  localparam int RLW =
    (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;

  state_e         state_q, state_d;
  logic [3:0]     pre_q, pre_d;
  logic           sticky_q, sticky_d;
  logic [RLW-1:0] rl_q, rl_d;
  logic           relock_q, relock_d;
  logic           eof_q, eof_d;
  logic [2:0]     err_q, err_d;

  logic        clr, ld_lo, emit;
  logic [10:0] byte_cnt;
  logic [3:0]  nib;
  logic        er;

  assign nib = io.in_d[3:0];
  assign er  = io.in_d[4];

  rx_nibble_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ld_lo    (ld_lo),
    .emit     (emit),
    .nib      (nib),
    .data     (io.out_data),
    .valid    (io.out_valid),
    .sof      (io.out_sof),
    .byte_cnt (byte_cnt)
  );

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    sticky_d = sticky_q;
    rl_d     = rl_q;
    relock_d = relock_q;
    eof_d    = 1'b0;
    err_d    = ERR_OK;
    clr      = 1'b0;
    ld_lo    = 1'b0;
    emit     = 1'b0;
    // Phase overflow overrides everything, including a frame end.
    if (io.in_ph_err) begin
      if (state_q == DATA_LO || state_q == DATA_HI) begin
        eof_d = 1'b1;
        err_d = ERR_PHASE;
      end
      state_d  = RELOCK;
      relock_d = 1'b1;
      rl_d     = RLW'(RELOCK_CYC - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.in_en) begin
            if (nib == NIB_PRE) begin
              state_d = PREAMBLE;
              pre_d   = 4'd1;
            end else begin
              state_d = DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!io.in_en) begin
            state_d = IDLE;
          end else if (nib == NIB_PRE) begin
            if (pre_q != 4'hF) pre_d = pre_q + 4'd1;
          end else if (nib == NIB_SFD &&
                       int'(pre_q) >= PRE_MIN) begin
            state_d  = DATA_LO;
            sticky_d = 1'b0;
            clr      = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
        DATA_LO: begin
          if (!io.in_en) begin
            eof_d   = 1'b1;
            state_d = IDLE;
            if (sticky_q)
              err_d = ERR_RXER;
            else if (int'(byte_cnt) < MIN_LEN)
              err_d = ERR_RUNT;
          end else begin
            ld_lo    = 1'b1;
            sticky_d = sticky_q | er;
            state_d  = DATA_HI;
          end
        end
        DATA_HI: begin
          if (!io.in_en) begin
            eof_d   = 1'b1;
            err_d   = ERR_ODD;
            state_d = IDLE;
          end else if (int'(byte_cnt) >= MAX_LEN) begin
            eof_d   = 1'b1;
            err_d   = ERR_LONG;
            state_d = DROP;
          end else begin
            emit     = 1'b1;
            sticky_d = sticky_q | er;
            state_d  = DATA_LO;
          end
        end
        DROP: begin
          if (!io.in_en) state_d = IDLE;
        end
        RELOCK: begin
          if (rl_q != '0) rl_d = rl_q - 1'b1;
          else relock_d = 1'b0;
          if (!relock_q && !io.in_en) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      sticky_q <= 1'b0;
      rl_q     <= '0;
      relock_q <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      sticky_q <= sticky_d;
      rl_q     <= rl_d;
      relock_q <= relock_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
    end
  end

  assign io.relock  = relock_q;
  assign io.out_eof = eof_q;
  assign io.out_err = err_q;
  assign io.busy    = (state_q != IDLE);

`ifdef FRAMER_STATS_EN
  logic [15:0] ok_q, ok_d;
  logic [15:0] bad_q, bad_d;
  logic [15:0] rlc_q, rlc_d;

  always_comb begin
    ok_d  = ok_q;
    bad_d = bad_q;
    rlc_d = rlc_q;
    if (eof_d && err_d == ERR_OK) ok_d = sat_inc16(ok_q);
    if (eof_d && err_d != ERR_OK) bad_d = sat_inc16(bad_q);
    if (io.in_ph_err && state_q != RELOCK)
      rlc_d = sat_inc16(rlc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_q  <= '0;
      bad_q <= '0;
      rlc_q <= '0;
    end else begin
      ok_q  <= ok_d;
      bad_q <= bad_d;
      rlc_q <= rlc_d;
    end
  end

  assign stat_ok     = ok_q;
  assign stat_err    = bad_q;
  assign stat_relock = rlc_q;
`endif
endmodule
